// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the multiply/divide scheduler.
// Imported by mdu_arith and mdu_sched.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2
  } mdu_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  localparam logic [3:0] MUL_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT = 4'd10;

  // True for the four ops that occupy the unit for multiple cycles.
  function automatic logic is_md_arith(input logic [2:0] op);
    return op <= OP_DIVU;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational signed/unsigned 32x32 multiply and 32/32 divide.
// Signed forms work on magnitudes and re-apply sign, so INT_MIN / -1 wraps to INT_MIN.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] prod_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = is_signed & a[31];
    b_neg     = is_signed & b[31];
    a_mag     = a_neg ? (32'd0 - a) : a;
    b_mag     = b_neg ? (32'd0 - b) : b;

    prod_mag  = {32'd0, a_mag} * {32'd0, b_mag};
    prod      = (a_neg ^ b_neg) ? (64'd0 - prod_mag) : prod_mag;

    // Zero divisor yields zeros here; the scheduler suppresses the write.
    div_zero  = (b == 32'd0);
    q_mag     = div_zero ? 32'd0 : (a_mag / b_mag);
    r_mag     = div_zero ? 32'd0 : (a_mag % b_mag);
    quot      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem       = a_neg ? (32'd0 - r_mag) : r_mag;
  end

endmodule

// File: rtl/mdu_sched.sv
// Multi-cycle HI/LO scheduler: latches the result at issue, holds busy for the
// fixed latency, then commits to HI/LO; also produces the D-stage stall.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | no operation in flight; MTHI/MTLO write directly
// ST_MUL_RUN | multiply result pending, cnt counting down from MUL_LAT
// ST_DIV_RUN | divide result pending, cnt counting down from DIV_LAT
module mdu_sched
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  hilo_t       pend_q, pend_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_zero;

  mdu_arith u_arith (
    .op       (op),
    .a        (a),
    .b        (b),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              pend_d.hi = prod[63:32];
              pend_d.lo = prod[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = MUL_LAT;
              state_d   = ST_MUL_RUN;
            end
            OP_DIV, OP_DIVU: begin
              // A zero divisor still occupies the unit but never commits.
              pend_d.hi = rem;
              pend_d.lo = quot;
              pend_wr_d = ~div_zero;
              cnt_d     = DIV_LAT;
              state_d   = ST_DIV_RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end

      ST_MUL_RUN, ST_DIV_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (pend_wr_q) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign stall_md = md_use_d & (busy | (start & is_md_arith(op)));
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: doc/mdu_sched.md
MDU_SCHED -- requirements
Module: mdu_sched

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have port start, input, 1 bit: E-stage multiply/divide instruction issues this cycle.
REQ-004 The module SHALL have port op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; values 6–7 are no-ops.
REQ-005 The module SHALL have ports a and b, input, 32 bits each: forwarded E-stage RS and RT operands.
REQ-006 The module SHALL have port md_use_d, input, 1 bit: the D-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
REQ-007 The module SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-008 The module SHALL have port stall_md, output, 1 bit: stall request to the D-stage stall logic.
REQ-009 The module SHALL have ports hi and lo, output, 32 bits each: architectural HI/LO for the MFHI/MFLO read path.

Function
REQ-010 The state machine SHALL have three states: IDLE, MUL_RUN and DIV_RUN, plus a 4-bit down-counter cnt.
REQ-011 In IDLE, start with op MULT/MULTU SHALL capture the 64-bit product into pending registers, load cnt=5, and move to MUL_RUN.
REQ-012 In IDLE, start with op DIV/DIVU SHALL capture quotient and remainder into pending registers, load cnt=10, and move to DIV_RUN.
REQ-013 In MUL_RUN or DIV_RUN, cnt SHALL decrement every cycle.
REQ-014 On the edge where cnt==1 the FSM SHALL write the pending values to HI/LO and return to IDLE.
REQ-015 busy SHALL equal (state != IDLE), so it is high for exactly 5 cycles for a multiply and 10 for a divide, starting the cycle after start.
REQ-016 New HI/LO values SHALL be visible the cycle after the last busy cycle.
REQ-017 MULT SHALL compute a signed 32x32 to 64 product; MULTU SHALL compute an unsigned one; HI SHALL take bits [63:32] and LO bits [31:0].
REQ-018 DIV SHALL truncate toward zero, giving the remainder the dividend's sign; LO SHALL take the quotient and HI the remainder.
REQ-019 DIVU SHALL be the unsigned equivalent of DIV.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0.
REQ-021 Division with b==0 SHALL still run 10 busy cycles and SHALL leave HI/LO unchanged at completion.
REQ-022 In IDLE, start with MTHI or MTLO SHALL write a to HI or LO at that edge, assert no busy, and cause no state change.
REQ-023 start while busy SHALL be ignored, with no effect on state, cnt or HI/LO; upstream stall logic guarantees it does not occur.
REQ-024 stall_md SHALL equal md_use_d & (busy | (start & op<=3)) and SHALL be combinational.
REQ-025 hi and lo SHALL be register outputs with no combinational bypass of pending results.

Reset
REQ-026 Asserting reset (low) SHALL immediately force IDLE, cnt=0, hi=0, lo=0, pending=0, busy=0 and stall_md=md_use_d&start&(op<=3), including when asserted mid-operation; the in-flight result is discarded.
REQ-027 After reset is released, the first accepted start SHALL behave identically to a start issued after a normal IDLE period.

Structure
REQ-028 Package mdu_pkg SHALL hold the op encodings, the state enum, and the constants MUL_LAT=5 and DIV_LAT=10.
REQ-029 The signed/unsigned multiply and divide arithmetic SHALL be a combinational sub-module, mdu_arith.
REQ-030 mdu_sched SHALL own only the FSM, cnt, the pending registers and HI/LO.

Verification
REQ-031 Bench scenario: MULT a=0xFFFFFFFE (-2), b=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFFA.
REQ-032 Bench scenario: DIVU a=100, b=7 -> busy high for 10 cycles, then lo=14 and hi=2; DIV a=-7, b=2 -> lo=0xFFFFFFFD and hi=0xFFFFFFFF.
REQ-033 Bench scenario: DIV with b=0 following MTHI 0x1234 and MTLO 0x5678 -> 10 busy cycles, after which hi=0x1234 and lo=0x5678.
REQ-034 Bench scenario: md_use_d held high during a MULT -> stall_md high on the start cycle plus 5 busy cycles (6 total), low on the 7th cycle.
REQ-035 Bench scenario: reset pulsed low at busy cycle 3 of a DIV -> busy=0, hi=lo=0 immediately, and no write at the would-be completion edge.
REQ-036 Bench scenario: MTLO 0xDEADBEEF issued in IDLE -> lo=0xDEADBEEF next cycle, busy stays 0, and stall_md stays 0 with md_use_d=1.
